// File: rtl/minibyte_pkg.sv
// -----------------------------------------------------------------------------
// minibyte_pkg
// Shared definitions for the MiniByte external memory bus arbiter:
//   - mem_state_e : access sequencer state encoding (2 bits)
//   - MEM_WAIT_W  : width of the bus-hold wait counter
// -----------------------------------------------------------------------------
package minibyte_pkg;

    localparam int MEM_WAIT_W = 4;

    typedef enum logic [1:0] {
        MEM_IDLE   = 2'd0,
        MEM_ACCESS = 2'd1,
        MEM_DONE   = 2'd2
    } mem_state_e;

endpackage : minibyte_pkg

// File: rtl/minibyte_mem_arb_if.sv
// -----------------------------------------------------------------------------
// minibyte_mem_arb_if
// Bundles the two requester ports and the shared external bus of the MiniByte
// memory arbiter. Signal suffixes are from the arbiter's point of view.
//   slave  : arbiter side (takes requests and read data, drives acks and bus)
//   master : environment side (requesters plus external memory)
// Requester n (n = 0 CPU memory port, n = 1 DFT program loader):
//   rn_req_in, rn_we_in, rn_addr_in[7:0], rn_wdata_in[7:0]   -> arbiter
//   rn_ack_out, rn_rdata_out[7:0]                            <- arbiter
// External bus:
//   bus_addr_out, bus_data_out, bus_we_out, bus_drive_out    <- arbiter
//   bus_data_in                                              -> arbiter
// Status: owner_out, busy_out                                <- arbiter
// -----------------------------------------------------------------------------
interface minibyte_mem_arb_if;

    logic       r0_req_in;
    logic       r0_we_in;
    logic [7:0] r0_addr_in;
    logic [7:0] r0_wdata_in;
    logic       r0_ack_out;
    logic [7:0] r0_rdata_out;

    logic       r1_req_in;
    logic       r1_we_in;
    logic [7:0] r1_addr_in;
    logic [7:0] r1_wdata_in;
    logic       r1_ack_out;
    logic [7:0] r1_rdata_out;

    logic [7:0] bus_addr_out;
    logic [7:0] bus_data_out;
    logic [7:0] bus_data_in;
    logic       bus_we_out;
    logic       bus_drive_out;

    logic       owner_out;
    logic       busy_out;

    modport slave (
        input  r0_req_in, r0_we_in, r0_addr_in, r0_wdata_in,
        input  r1_req_in, r1_we_in, r1_addr_in, r1_wdata_in,
        input  bus_data_in,
        output r0_ack_out, r0_rdata_out, r1_ack_out, r1_rdata_out,
        output bus_addr_out, bus_data_out, bus_we_out, bus_drive_out,
        output owner_out, busy_out
    );

    modport master (
        output r0_req_in, r0_we_in, r0_addr_in, r0_wdata_in,
        output r1_req_in, r1_we_in, r1_addr_in, r1_wdata_in,
        output bus_data_in,
        input  r0_ack_out, r0_rdata_out, r1_ack_out, r1_rdata_out,
        input  bus_addr_out, bus_data_out, bus_we_out, bus_drive_out,
        input  owner_out, busy_out
    );

endinterface : minibyte_mem_arb_if

// File: rtl/minibyte_rr_arb2.sv
// -----------------------------------------------------------------------------
// minibyte_rr_arb2
// Combinational two-way round-robin pick.
//   req0_i, req1_i  : request lines
//   last_owner_i    : index of the most recent grant
//   grant_valid_o   : at least one request is pending
//   grant_idx_o     : winning requester (under contention, the one that is
//                     not last_owner_i)
// -----------------------------------------------------------------------------
module minibyte_rr_arb2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_owner_i,
    output logic grant_valid_o,
    output logic grant_idx_o
);

    always_comb begin
        grant_valid_o = req0_i | req1_i;
        if (req0_i && req1_i) begin
            grant_idx_o = ~last_owner_i;
        end else begin
            grant_idx_o = req1_i;
        end
    end

endmodule : minibyte_rr_arb2

// File: rtl/minibyte_mem_arb.sv
// -----------------------------------------------------------------------------
// minibyte_mem_arb
// Two-port round-robin arbiter and access sequencer for the MiniByte 8-bit
// external memory/IO bus. A granted access holds address, data and strobes for
// WAIT_CYCLES+1 cycles, captures read data on the last one, then pulses the
// owner's ack for one cycle before returning to IDLE.
//   WAIT_CYCLES : extra bus-hold cycles per access (0..15)
//   clk_in      : system clock, rising edge
//   rst_in      : asynchronous active-high reset
//   bus_if      : requester ports, external bus and status (slave modport)
// All outputs are decoded from registers only.
// -----------------------------------------------------------------------------
module minibyte_mem_arb
    import minibyte_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic               clk_in,
    input  logic               rst_in,
    minibyte_mem_arb_if.slave  bus_if
);

    localparam logic [MEM_WAIT_W-1:0] WAIT_LAST = MEM_WAIT_W'(WAIT_CYCLES);
    localparam logic [MEM_WAIT_W-1:0] CNT_ONE   = MEM_WAIT_W'(1);

    mem_state_e            state_q, state_d;
    logic [MEM_WAIT_W-1:0] cnt_q,   cnt_d;
    logic                  owner_q, owner_d;
    logic [7:0]            addr_q,  addr_d;
    logic [7:0]            wdata_q, wdata_d;
    logic                  we_q,    we_d;
    logic [7:0]            rdata0_q, rdata0_d;
    logic [7:0]            rdata1_q, rdata1_d;

    logic grant_valid;
    logic grant_idx;

    logic ack0, ack1, bus_we;

    minibyte_rr_arb2 u_rr_arb (
        .req0_i        (bus_if.r0_req_in),
        .req1_i        (bus_if.r1_req_in),
        .last_owner_i  (owner_q),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx)
    );

    // State register. owner resets to 1 so requester 0 wins the first
    // contended grant.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // NOTE: the read-data registers are reset too: they are architectural
    // outputs that must read 0 after reset, not a storage array.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= MEM_IDLE;
            cnt_q    <= '0;
            owner_q  <= 1'b1;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Next-state logic.
    // NOTE: every signal gets a hold-value default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        unique case (state_q)
            MEM_IDLE: begin
                if (grant_valid) begin
                    // Snapshot the winner's request so later input changes
                    // cannot disturb the access in flight.
                    state_d = MEM_ACCESS;
                    owner_d = grant_idx;
                    cnt_d   = '0;
                    addr_d  = grant_idx ? bus_if.r1_addr_in  : bus_if.r0_addr_in;
                    wdata_d = grant_idx ? bus_if.r1_wdata_in : bus_if.r0_wdata_in;
                    we_d    = grant_idx ? bus_if.r1_we_in    : bus_if.r0_we_in;
                end
            end
            MEM_ACCESS: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == WAIT_LAST) begin
                    state_d = MEM_DONE;
                    // Read data is captured on the edge ending the last
                    // ACCESS cycle, into the owner's register only.
                    if (!we_q) begin
                        if (owner_q) begin
                            rdata1_d = bus_if.bus_data_in;
                        end else begin
                            rdata0_d = bus_if.bus_data_in;
                        end
                    end
                end
            end
            MEM_DONE: begin
                state_d = MEM_IDLE;
            end
            default: begin
                state_d = MEM_IDLE;
            end
        endcase
    end

    // Output decode from registered state.
    always_comb begin
        ack0   = 1'b0;
        ack1   = 1'b0;
        bus_we = 1'b0;
        unique case (state_q)
            MEM_ACCESS: bus_we = we_q;
            MEM_DONE: begin
                if (owner_q) begin
                    ack1 = 1'b1;
                end else begin
                    ack0 = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus_if.r0_ack_out    = ack0;
    assign bus_if.r1_ack_out    = ack1;
    assign bus_if.r0_rdata_out  = rdata0_q;
    assign bus_if.r1_rdata_out  = rdata1_q;
    assign bus_if.bus_addr_out  = addr_q;
    assign bus_if.bus_data_out  = wdata_q;
    assign bus_if.bus_we_out    = bus_we;
    assign bus_if.bus_drive_out = bus_we;
    assign bus_if.owner_out     = owner_q;
    assign bus_if.busy_out      = (state_q != MEM_IDLE);

endmodule : minibyte_mem_arb

// File: tb/tb_minibyte_mem_arb.sv
// -----------------------------------------------------------------------------
// tb_minibyte_mem_arb
// Directed testbench for minibyte_mem_arb. Three instances share clock and
// reset: WAIT_CYCLES = 1 (main scenarios), 0 and 15 (latency sweep).
// Cycle 0 is the IDLE cycle in which a request is first presented; outputs
// are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_minibyte_mem_arb;

    logic clk;
    logic rst;

    int passed = 0;
    int total  = 0;

    minibyte_mem_arb_if ifc0 ();
    minibyte_mem_arb_if ifc1 ();
    minibyte_mem_arb_if ifc15 ();

    minibyte_mem_arb #(.WAIT_CYCLES(0))  dut0  (.clk_in(clk), .rst_in(rst), .bus_if(ifc0));
    minibyte_mem_arb #(.WAIT_CYCLES(1))  dut1  (.clk_in(clk), .rst_in(rst), .bus_if(ifc1));
    minibyte_mem_arb #(.WAIT_CYCLES(15)) dut15 (.clk_in(clk), .rst_in(rst), .bus_if(ifc15));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic init_inputs();
        ifc0.r0_req_in = 0;  ifc0.r0_we_in = 0;  ifc0.r0_addr_in = 0;  ifc0.r0_wdata_in = 0;
        ifc0.r1_req_in = 0;  ifc0.r1_we_in = 0;  ifc0.r1_addr_in = 0;  ifc0.r1_wdata_in = 0;
        ifc0.bus_data_in = 0;
        ifc1.r0_req_in = 0;  ifc1.r0_we_in = 0;  ifc1.r0_addr_in = 0;  ifc1.r0_wdata_in = 0;
        ifc1.r1_req_in = 0;  ifc1.r1_we_in = 0;  ifc1.r1_addr_in = 0;  ifc1.r1_wdata_in = 0;
        ifc1.bus_data_in = 0;
        ifc15.r0_req_in = 0; ifc15.r0_we_in = 0; ifc15.r0_addr_in = 0; ifc15.r0_wdata_in = 0;
        ifc15.r1_req_in = 0; ifc15.r1_we_in = 0; ifc15.r1_addr_in = 0; ifc15.r1_wdata_in = 0;
        ifc15.bus_data_in = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({ifc1.r0_ack_out, ifc1.r1_ack_out, ifc1.bus_we_out, ifc1.bus_drive_out, ifc1.busy_out} !== 5'b0) begin
            $display("FAIL reset_strobes: ack0,ack1,we,drive,busy = %b required 00000",
                     {ifc1.r0_ack_out, ifc1.r1_ack_out, ifc1.bus_we_out, ifc1.bus_drive_out, ifc1.busy_out});
        end else passed++;
        total++;
        if ({ifc1.bus_addr_out, ifc1.bus_data_out} !== 16'h0000) begin
            $display("FAIL reset_bus: addr,data = %h required 0000", {ifc1.bus_addr_out, ifc1.bus_data_out});
        end else passed++;
        total++;
        if ({ifc1.r0_rdata_out, ifc1.r1_rdata_out} !== 16'h0000) begin
            $display("FAIL reset_rdata: rdata0,rdata1 = %h required 0000", {ifc1.r0_rdata_out, ifc1.r1_rdata_out});
        end else passed++;
        total++;
        if (ifc1.owner_out !== 1'b1) begin
            $display("FAIL reset_owner: owner = %b required 1", ifc1.owner_out);
        end else passed++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        next_cycle();
        ifc1.r0_we_in   = 1'b0;
        ifc1.r0_addr_in = 8'h3C;
        ifc1.bus_data_in = 8'hA5;
        ifc1.r0_req_in  = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            if (c == 1) ifc1.r0_req_in = 1'b0;
            if (c <= 2) begin
                total++;
                if (ifc1.bus_addr_out !== 8'h3C) begin
                    $display("FAIL read_addr c%0d: addr = %h required 3c", c, ifc1.bus_addr_out);
                end else passed++;
            end
            total++;
            if (ifc1.r0_ack_out !== (c == 3)) begin
                $display("FAIL read_ack c%0d: ack0 = %b required %b", c, ifc1.r0_ack_out, (c == 3));
            end else passed++;
            if (c == 3) begin
                total++;
                if (ifc1.r0_rdata_out !== 8'hA5) begin
                    $display("FAIL read_rdata_at_ack: rdata0 = %h required a5", ifc1.r0_rdata_out);
                end else passed++;
            end
        end
        total++;
        if (ifc1.r1_rdata_out !== 8'h00) begin
            $display("FAIL read_other_rdata: rdata1 = %h required 00", ifc1.r1_rdata_out);
        end else passed++;
    endtask

    task automatic test_single_write();
        int strobe_cnt = 0;
        int any_cnt    = 0;
        int ack_cnt    = 0;
        next_cycle();
        ifc1.r1_we_in    = 1'b1;
        ifc1.r1_addr_in  = 8'h10;
        ifc1.r1_wdata_in = 8'h5A;
        ifc1.r1_req_in   = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            if (c == 1) ifc1.r1_req_in = 1'b0;
            if (ifc1.bus_we_out && ifc1.bus_drive_out && ifc1.bus_data_out == 8'h5A && ifc1.bus_addr_out == 8'h10)
                strobe_cnt++;
            if (ifc1.bus_we_out || ifc1.bus_drive_out) any_cnt++;
            if (ifc1.r1_ack_out) ack_cnt++;
        end
        total++;
        if (strobe_cnt != 2) begin
            $display("FAIL write_strobe_cycles: %0d cycles required 2", strobe_cnt);
        end else passed++;
        total++;
        if (any_cnt != 2) begin
            $display("FAIL write_we_cycles: %0d cycles required 2", any_cnt);
        end else passed++;
        total++;
        if (ack_cnt != 1) begin
            $display("FAIL write_ack_count: %0d pulses required 1", ack_cnt);
        end else passed++;
        total++;
        if ({ifc1.r0_rdata_out, ifc1.r1_rdata_out} !== 16'hA500) begin
            $display("FAIL write_rdata_kept: rdata0,rdata1 = %h required a500", {ifc1.r0_rdata_out, ifc1.r1_rdata_out});
        end else passed++;
        ifc1.r1_we_in = 1'b0;
    endtask

    task automatic test_mid_access();
        next_cycle();
        ifc1.r0_we_in    = 1'b0;
        ifc1.r0_addr_in  = 8'h44;
        ifc1.bus_data_in = 8'h77;
        ifc1.r0_req_in   = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            if (c == 1) begin
                ifc1.r0_req_in   = 1'b0;
                ifc1.r0_addr_in  = 8'hFF;
                ifc1.r0_we_in    = 1'b1;
                ifc1.r0_wdata_in = 8'hEE;
                #1;
            end
            if (c <= 2) begin
                total++;
                if (ifc1.bus_addr_out !== 8'h44 || ifc1.bus_we_out !== 1'b0) begin
                    $display("FAIL mid_latched c%0d: addr = %h we = %b required 44 0", c, ifc1.bus_addr_out, ifc1.bus_we_out);
                end else passed++;
            end
            total++;
            if (ifc1.r0_ack_out !== (c == 3)) begin
                $display("FAIL mid_ack c%0d: ack0 = %b required %b", c, ifc1.r0_ack_out, (c == 3));
            end else passed++;
        end
        total++;
        if (ifc1.r0_rdata_out !== 8'h77) begin
            $display("FAIL mid_rdata: rdata0 = %h required 77", ifc1.r0_rdata_out);
        end else passed++;
        ifc1.r0_we_in = 1'b0;
    endtask

    task automatic test_contention();
        int n = 0;
        int ack_cyc [4];
        logic ack_own [4];
        int both = 0;
        bit idle_seen = 0;
        @(negedge clk);
        rst = 1'b1;
        ifc1.r0_we_in = 1'b0; ifc1.r0_addr_in = 8'h01;
        ifc1.r1_we_in = 1'b0; ifc1.r1_addr_in = 8'h02;
        ifc1.bus_data_in = 8'hC3;
        ifc1.r0_req_in = 1'b1;
        ifc1.r1_req_in = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            next_cycle();
            if (ifc1.r0_ack_out && ifc1.r1_ack_out) both++;
            if ((ifc1.r0_ack_out || ifc1.r1_ack_out) && n < 4) begin
                ack_cyc[n] = c;
                ack_own[n] = ifc1.r1_ack_out;
                n++;
            end
        end
        ifc1.r0_req_in = 1'b0;
        ifc1.r1_req_in = 1'b0;
        total++;
        if (n != 4 || both != 0) begin
            $display("FAIL contention_count: %0d acks (%0d double) required 4 (0)", n, both);
        end else passed++;
        for (int i = 0; i < n; i++) begin
            total++;
            if (ack_own[i] !== i[0] || ack_cyc[i] != 3 + 4 * i) begin
                $display("FAIL contention_ack%0d: owner %b cycle %0d required %b cycle %0d",
                         i, ack_own[i], ack_cyc[i], i[0], 3 + 4 * i);
            end else passed++;
        end
        for (int k = 0; k < 10 && !idle_seen; k++) begin
            next_cycle();
            if (!ifc1.busy_out) idle_seen = 1;
        end
        total++;
        if (!idle_seen) begin
            $display("FAIL contention_drain: busy = %b required 0 within 10 cycles", ifc1.busy_out);
        end else passed++;
    endtask

    task automatic test_reset_mid_access();
        int ack_cnt = 0;
        next_cycle();
        ifc1.r1_we_in    = 1'b1;
        ifc1.r1_addr_in  = 8'h20;
        ifc1.r1_wdata_in = 8'h99;
        ifc1.r1_req_in   = 1'b1;
        next_cycle();
        ifc1.r1_req_in = 1'b0;
        total++;
        if (ifc1.bus_we_out !== 1'b1 || ifc1.bus_drive_out !== 1'b1) begin
            $display("FAIL rstmid_pre: we = %b drive = %b required 1 1", ifc1.bus_we_out, ifc1.bus_drive_out);
        end else passed++;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (ifc1.bus_we_out !== 1'b0 || ifc1.bus_drive_out !== 1'b0 || ifc1.busy_out !== 1'b0) begin
            $display("FAIL rstmid_async: we = %b drive = %b busy = %b required 0 0 0",
                     ifc1.bus_we_out, ifc1.bus_drive_out, ifc1.busy_out);
        end else passed++;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            if (ifc1.r0_ack_out || ifc1.r1_ack_out) ack_cnt++;
        end
        total++;
        if (ack_cnt != 0) begin
            $display("FAIL rstmid_no_ack: %0d acks required 0", ack_cnt);
        end else passed++;
        total++;
        if (ifc1.busy_out !== 1'b0 || ifc1.owner_out !== 1'b1) begin
            $display("FAIL rstmid_idle: busy = %b owner = %b required 0 1", ifc1.busy_out, ifc1.owner_out);
        end else passed++;
        total++;
        if (ifc1.r0_rdata_out !== 8'h00) begin
            $display("FAIL rstmid_rdata: rdata0 = %h required 00", ifc1.r0_rdata_out);
        end else passed++;
        ifc1.r1_we_in = 1'b0;
    endtask

    task automatic test_wait_sweep();
        int a0  = 0;
        int a15 = 0;
        next_cycle();
        ifc0.r0_we_in  = 1'b0; ifc0.r0_addr_in  = 8'h08; ifc0.bus_data_in  = 8'h11;
        ifc15.r0_we_in = 1'b0; ifc15.r0_addr_in = 8'h09; ifc15.bus_data_in = 8'hF0;
        ifc0.r0_req_in  = 1'b1;
        ifc15.r0_req_in = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            next_cycle();
            if (c == 1) begin
                ifc0.r0_req_in  = 1'b0;
                ifc15.r0_req_in = 1'b0;
            end
            if (ifc0.r0_ack_out && a0 == 0) a0 = c;
            if (ifc15.r0_ack_out && a15 == 0) a15 = c;
        end
        total++;
        if (a0 != 2) begin
            $display("FAIL sweep_wc0_ack: cycle %0d required 2", a0);
        end else passed++;
        total++;
        if (a15 != 17) begin
            $display("FAIL sweep_wc15_ack: cycle %0d required 17", a15);
        end else passed++;
        total++;
        if ({ifc0.r0_rdata_out, ifc15.r0_rdata_out} !== 16'h11F0) begin
            $display("FAIL sweep_rdata: wc0,wc15 rdata0 = %h required 11f0", {ifc0.r0_rdata_out, ifc15.r0_rdata_out});
        end else passed++;
    endtask

    initial begin
        rst = 1'b1;
        init_inputs();
        test_reset();
        test_single_read();
        test_single_write();
        test_mid_access();
        test_contention();
        test_reset_mid_access();
        test_wait_sweep();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_minibyte_mem_arb

// File: doc/minibyte_mem_arb.md
# minibyte_mem_arb

Two-port memory bus arbiter and access sequencer for the MiniByte external 8-bit memory/IO bus. It sits between two bus masters and the single shared external bus: requester 0 is the CPU core's memory port, requester 1 is the DFT program loader. It grants the bus round-robin, holds address, data and strobes stable for a programmable number of wait cycles, captures read data, and returns a one-cycle acknowledge to the owning requester.

## Interface
Parameters:
- WAIT_CYCLES, default 1: extra bus-hold cycles per access; legal range 0..15.

Ports:
- clk_in  input  1  system clock; all state updates on the rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- r0_req_in / r1_req_in  input  1  access request from requester 0 / 1.
- r0_we_in / r1_we_in  input  1  1 = write, 0 = read.
- r0_addr_in / r1_addr_in  input  8  access address.
- r0_wdata_in / r1_wdata_in  input  8  write data.
- r0_ack_out / r1_ack_out  output  1  one-cycle completion pulse.
- r0_rdata_out / r1_rdata_out  output  8  last read data for that requester.
- bus_addr_out  output  8  external address.
- bus_data_out  output  8  external write data.
- bus_data_in  input  8  external read data.
- bus_we_out  output  1  external write enable.
- bus_drive_out  output  1  data-pin output enable.
- owner_out  output  1  requester index of the current or most recent grant.
- busy_out  output  1  high while state is not IDLE.

## Operation
- States: IDLE, ACCESS, DONE. Encoding is 2 bits.
- IDLE:
  - Requests are sampled only in this state.
  - If exactly one req is high, grant that requester.
  - If both are high, grant the requester that is not owner_out (round-robin).
  - On grant: latch that requester's addr, wdata and we into internal registers, set owner_out, clear the wait counter, go to ACCESS.
  - No req: stay in IDLE.
- ACCESS:
  - Lasts exactly WAIT_CYCLES+1 cycles; a 4-bit counter increments each cycle.
  - bus_addr_out = latched addr throughout.
  - Write: bus_data_out = latched wdata, and bus_we_out = bus_drive_out = 1 for every ACCESS cycle.
  - Read: bus_we_out = bus_drive_out = 0.
  - On the final ACCESS cycle (counter == WAIT_CYCLES), a read samples bus_data_in into the owner's rdata register, then the block goes to DONE.
- DONE:
  - The owner's ack pulses high for exactly one cycle.
  - Bus strobes are low.
  - Unconditional return to IDLE, which gives one turnaround cycle before the next grant.
- rdata registers:
  - Each port's rdata_out changes only on that port's read completion.
  - Writes never modify rdata.
  - rdata_out is valid from the ack cycle onward and holds until the next read by that port.
- Request deasserted during ACCESS: ignored. The access completes and ack still pulses.
- Changes on addr/wdata/we inputs after grant have no effect on the access in flight.
- A requester holding req high through ack is treated as a new request in the following IDLE cycle.
- Under continuous contention the requesters strictly alternate.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE, counter = 0.
  - owner_out = 1, so requester 0 wins the first contended grant.
  - All acks = 0, bus_we_out = bus_drive_out = 0, bus_addr_out = bus_data_out = 0.
  - Both rdata_out = 0, busy_out = 0.
- Reset mid-access: the access is aborted, no ack is issued, and the rdata registers are cleared.
- All outputs are decoded from registers only; there is no combinational input-to-output path.
- Latency from req high in IDLE (cycle 0) with the bus free:
  - ACCESS spans cycles 1..WAIT_CYCLES+1.
  - ack is high on cycle WAIT_CYCLES+2.
  - The next grant is possible on cycle WAIT_CYCLES+3.
- Throughput: one access per WAIT_CYCLES+3 cycles. With WAIT_CYCLES=0: ACCESS is 1 cycle, ack on cycle 2.
- Read sampling: bus_data_in is captured at the rising edge that ends the last ACCESS cycle.

## Structure
- Shared package minibyte_pkg holds:
  - state encodings MEM_IDLE = 2'd0, MEM_ACCESS = 2'd1, MEM_DONE = 2'd2;
  - the counter width constant MEM_WAIT_W = 4.
- One sub-module, minibyte_rr_arb2: combinational 2-way round-robin pick from (req0, req1, last_owner) producing (grant_valid, grant_idx).
- Everything else lives in minibyte_mem_arb.

## Test plan
- Single read, WAIT_CYCLES=1:
  - Stimulus: r0 reads addr 0x3C, memory model returns 0xA5.
  - Required: bus_addr_out=0x3C on cycles 1-2, r0_ack_out high on cycle 3 only, r0_rdata_out=0xA5, r1_rdata_out stays 0x00.
- Single write:
  - Stimulus: r1 writes 0x5A to 0x10.
  - Required: bus_we_out=bus_drive_out=1 and bus_data_out=0x5A for exactly WAIT_CYCLES+1 cycles, r1_ack_out pulses once, r1_rdata_out unchanged.
- Contention:
  - Stimulus: both reqs held high from reset release.
  - Required: grant order r0, r1, r0, r1; acks alternate, spaced WAIT_CYCLES+3 cycles apart.
- Mid-access changes:
  - Stimulus: r0 deasserts req and changes addr to 0xFF during ACCESS.
  - Required: bus_addr_out keeps the latched value, and r0_ack_out still pulses.
- Reset mid-access:
  - Stimulus: assert rst_in during the ACCESS of a write.
  - Required: bus_we_out and bus_drive_out drop without waiting for a clock edge, no ack is issued, the block is IDLE after release, and owner_out=1.
- WAIT_CYCLES sweep:
  - Stimulus: WAIT_CYCLES=0 and WAIT_CYCLES=15.
  - Required: ack on cycle 2 and cycle 17 respectively.
